compare_branch: RTL and testbench
=================================

COMPARE_BRANCH -- requirements
Module: compare_branch

Interface
REQ-001 Parameter: Width, 32, operand and payload width.
REQ-002 Parameter: Timeout, 1024, max clk cycles spent waiting on comparator before abort.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_req  in  1  upstream 4-phase request.
REQ-007 in_ack  out  1  upstream 4-phase acknowledge.
REQ-008 in_x, in_y  in  Width  operands, stable while in_req high.
REQ-009 in_cond  in  3  condition code.
REQ-010 in_data  in  Width  payload forwarded to the taken branch.
REQ-011 cmp_req  out  1  request to comparator.
REQ-012 cmp_x, cmp_y  out  Width  registered operands to comparator.
REQ-013 cmp_fin  in  1  comparator done; asynchronous to clk.
REQ-014 cmp_bigger, cmp_equal, cmp_smaller  in  1  comparator one-hot result.
REQ-015 t_req / t_ack  out / in  1  true-branch 4-phase handshake.
REQ-016 f_req / f_ack  out / in  1  false-branch 4-phase handshake.
REQ-017 out_data  out  Width  registered payload, stable while t_req or f_req high.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 FSM states: IDLE, ARM, WAIT_LO, WAIT_HI, EVAL, DISP, RTZ.
REQ-020 IDLE: when in_req=1, in_ack=0, t_ack=0, f_ack=0, latch in_x/in_y into cmp_x/cmp_y, in_cond, in_data into out_data; go ARM.
REQ-021 ARM: cmp_req stays 0 for exactly one cycle so operands settle before cmp_req rises; go WAIT_LO.
REQ-022 WAIT_LO: cmp_req=1; wait for synchronized fin=0, discarding stale fin from the previous operation; go WAIT_HI.
REQ-023 WAIT_HI: cmp_req=1; wait for synchronized fin=1; go EVAL.
REQ-024 EVAL: sample raw flags once; cmp_req returns to 0; compute taken = f(cond, flags); go DISP.
REQ-025 Condition codes: 0 EQ(equal), 1 NE(~equal), 2 LT(smaller), 3 LE(smaller|equal), 4 GT(bigger), 5 GE(bigger|equal), 6 ALWAYS, 7 NEVER.
REQ-026 Codes 6 and 7 still run the full compare sequence; result ignored.
REQ-027 DISP: assert t_req if taken else f_req; hold until the matching ack=1; then drop req, raise in_ack, go RTZ.
REQ-028 RTZ: hold in_ack=1 until in_req=0 and selected ack=0; then in_ack=0, go IDLE.
REQ-029 Exactly one of t_req, f_req is high at any time; never both.
REQ-030 Wait counter clears on entering WAIT_LO and counts cycles in WAIT_LO+WAIT_HI; reaching Timeout sets err, drops cmp_req, skips dispatch, raises in_ack, goes RTZ.
REQ-031 err clears only on rst.
REQ-032 EVAL flags not one-hot (protocol violation): treat as not-taken; err unaffected.
REQ-033 in_req dropping before in_ack is a protocol violation; the block completes the transaction regardless.
REQ-034 Minimum latency from in_req=1 to t_req/f_req=1: 7 cycles with a zero-delay comparator (1 capture, 1 ARM, 2-cycle sync low, 2-cycle sync high, 1 EVAL).

Reset
REQ-035 rst forces IDLE and clears in_ack, cmp_req, t_req, f_req, err, wait counter, synchronizer flops, cmp_x, cmp_y, out_data.
REQ-036 Mid-transaction rst abandons the transaction without dispatch; the first cycle after rst deasserts is IDLE.

Structure
REQ-037 State enum and the condition-code constants (COND_EQ..COND_NEVER) live in shared package flowcontrol_pkg.
REQ-038 cmp_fin passes through one sub-module, sync2 (two-flop synchronizer, reset to 0).
REQ-039 Flags are not synchronized; they are sampled only in EVAL, when fin has been high at least 2 cycles.

Verification
REQ-040 x=5,y=3,cond=GT, comparator delay 3 cycles -> t_req=1, out_data=in_data, f_req=0; after t_ack handshake, in_ack 4-phase completes.
REQ-041 x=7,y=7,cond=NE -> f_req=1; repeat with cond=LE -> t_req=1.
REQ-042 Back-to-back transactions with comparator fin left high from the previous op -> block waits for fin low then high; no early EVAL.
REQ-043 Comparator never raises fin, Timeout=16 -> err=1 at cycle 16 of waiting, no t_req/f_req, in_ack=1, block returns to IDLE.
REQ-044 rst asserted in WAIT_HI and in DISP -> all outputs 0 the next cycle; a new transaction x=1,y=2,cond=LT then yields t_req.
REQ-045 Zero-delay comparator, cond=ALWAYS -> t_req rises exactly 7 cycles after in_req.

Source files
------------

// File: rtl/flowcontrol_pkg.sv
// Shared FSM states, condition codes and the branch decision for compare_branch.
package flowcontrol_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_LO,
    WAIT_HI,
    EVAL,
    DISP,
    RTZ
  } state_t;

  localparam logic [2:0] COND_EQ     = 3'd0;
  localparam logic [2:0] COND_NE     = 3'd1;
  localparam logic [2:0] COND_LT     = 3'd2;
  localparam logic [2:0] COND_LE     = 3'd3;
  localparam logic [2:0] COND_GT     = 3'd4;
  localparam logic [2:0] COND_GE     = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;
  localparam logic [2:0] COND_NEVER  = 3'd7;

  // Flag-based codes fall back to not-taken when the comparator breaks one-hot.
  function automatic logic cond_taken(input logic [2:0] cond, input logic bigger,
                                      input logic equal, input logic smaller);
    logic one_hot;
    logic taken;
    one_hot = (bigger ^ equal ^ smaller) & ~(bigger & equal & smaller);
    case (cond)
      COND_EQ:     taken = equal;
      COND_NE:     taken = ~equal;
      COND_LT:     taken = smaller;
      COND_LE:     taken = smaller | equal;
      COND_GT:     taken = bigger;
      COND_GE:     taken = bigger | equal;
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
    if (cond != COND_ALWAYS && cond != COND_NEVER && !one_hot) begin
      taken = 1'b0;
    end
    return taken;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared by reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/compare_branch.sv
// Sends two operands to an asynchronous comparator over a 4-phase handshake and
// dispatches the payload to the true or false branch according to a condition code.
module compare_branch
  import flowcontrol_pkg::*;
#(
  parameter int Width   = 32,
  parameter int Timeout = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_req,
  output logic             in_ack,
  input  logic [Width-1:0] in_x,
  input  logic [Width-1:0] in_y,
  input  logic [2:0]       in_cond,
  input  logic [Width-1:0] in_data,
  output logic             cmp_req,
  output logic [Width-1:0] cmp_x,
  output logic [Width-1:0] cmp_y,
  input  logic             cmp_fin,
  input  logic             cmp_bigger,
  input  logic             cmp_equal,
  input  logic             cmp_smaller,
  output logic             t_req,
  input  logic             t_ack,
  output logic             f_req,
  input  logic             f_ack,
  output logic [Width-1:0] out_data,
  output logic             err
);

  localparam int CntW = $clog2(Timeout + 1);

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             in_ack_q, in_ack_d;
  logic             cmp_req_q, cmp_req_d;
  logic             t_req_q, t_req_d;
  logic             f_req_q, f_req_d;
  logic             err_q, err_d;
  logic [Width-1:0] cmp_x_q, cmp_x_d;
  logic [Width-1:0] cmp_y_q, cmp_y_d;
  logic [Width-1:0] out_data_q, out_data_d;
  logic [2:0]       cond_q, cond_d;
  logic [1:0]       branch_q, branch_d;
  logic             fin_s;
  logic             taken;
  logic             timeout_hit;
  logic             sel_ack;

  sync2 u_fin_sync (
    .clk (clk),
    .rst (rst),
    .d_i (cmp_fin),
    .q_o (fin_s)
  );

  assign timeout_hit = (cnt_q == CntW'(Timeout - 1));
  // branch_q remembers which side was dispatched (none after a timeout).
  assign sel_ack     = (branch_q[1] & t_ack) | (branch_q[0] & f_ack);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    in_ack_d   = in_ack_q;
    cmp_req_d  = cmp_req_q;
    t_req_d    = t_req_q;
    f_req_d    = f_req_q;
    err_d      = err_q;
    cmp_x_d    = cmp_x_q;
    cmp_y_d    = cmp_y_q;
    out_data_d = out_data_q;
    cond_d     = cond_q;
    branch_d   = branch_q;
    taken      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_req && !t_ack && !f_ack) begin
          cmp_x_d    = in_x;
          cmp_y_d    = in_y;
          cond_d     = in_cond;
          out_data_d = in_data;
          state_d    = ARM;
        end
      end
      ARM: begin
        cnt_d     = '0;
        seen_d    = 1'b0;
        cmp_req_d = 1'b1;
        state_d   = WAIT_LO;
      end
      WAIT_LO, WAIT_HI: begin
        if (timeout_hit) begin
          err_d     = 1'b1;
          cmp_req_d = 1'b0;
          in_ack_d  = 1'b1;
          branch_d  = 2'b00;
          state_d   = RTZ;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == WAIT_LO) begin
            seen_d = 1'b0;
            if (!fin_s) begin
              state_d = WAIT_HI;
            end
          end else begin
            // Two consecutive high samples guarantee the raw flags have settled.
            seen_d = fin_s;
            if (fin_s && seen_q) begin
              cmp_req_d = 1'b0;
              state_d   = EVAL;
            end
          end
        end
      end
      EVAL: begin
        taken    = cond_taken(cond_q, cmp_bigger, cmp_equal, cmp_smaller);
        t_req_d  = taken;
        f_req_d  = ~taken;
        branch_d = {taken, ~taken};
        state_d  = DISP;
      end
      DISP: begin
        if (sel_ack) begin
          t_req_d  = 1'b0;
          f_req_d  = 1'b0;
          in_ack_d = 1'b1;
          state_d  = RTZ;
        end
      end
      RTZ: begin
        if (!in_req && !sel_ack) begin
          in_ack_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      in_ack_q   <= 1'b0;
      cmp_req_q  <= 1'b0;
      t_req_q    <= 1'b0;
      f_req_q    <= 1'b0;
      err_q      <= 1'b0;
      cmp_x_q    <= '0;
      cmp_y_q    <= '0;
      out_data_q <= '0;
      cond_q     <= COND_EQ;
      branch_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      in_ack_q   <= in_ack_d;
      cmp_req_q  <= cmp_req_d;
      t_req_q    <= t_req_d;
      f_req_q    <= f_req_d;
      err_q      <= err_d;
      cmp_x_q    <= cmp_x_d;
      cmp_y_q    <= cmp_y_d;
      out_data_q <= out_data_d;
      cond_q     <= cond_d;
      branch_q   <= branch_d;
    end
  end

  assign in_ack   = in_ack_q;
  assign cmp_req  = cmp_req_q;
  assign cmp_x    = cmp_x_q;
  assign cmp_y    = cmp_y_q;
  assign t_req    = t_req_q;
  assign f_req    = f_req_q;
  assign out_data = out_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_compare_branch.sv
// Randomized self-checking bench for compare_branch with a behavioural comparator
// and a condition-code reference model.
module tb_compare_branch;

  localparam int W  = 32;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_req, in_ack;
  logic [W-1:0] in_x, in_y, in_data;
  logic [2:0]   in_cond;
  logic         cmp_req, cmp_fin, cmp_bigger, cmp_equal, cmp_smaller;
  logic [W-1:0] cmp_x, cmp_y, out_data;
  logic         t_req, t_ack, f_req, f_ack, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int both_cnt = 0;

  // Comparator model knobs and state
  int   cmp_delay = 3;
  int   lo_delay  = 0;
  bit   cmp_never = 1'b0;
  int   flag_mode = 0;
  logic fin_reg = 1'b0;
  logic rel = 1'b0;
  int   hi_cnt = 0;
  int   lo_cnt = 0;
  int   rise_cyc = 0;

  compare_branch #(.Width(W), .Timeout(TO)) dut (
    .clk (clk), .rst (rst),
    .in_req (in_req), .in_ack (in_ack),
    .in_x (in_x), .in_y (in_y), .in_cond (in_cond), .in_data (in_data),
    .cmp_req (cmp_req), .cmp_x (cmp_x), .cmp_y (cmp_y), .cmp_fin (cmp_fin),
    .cmp_bigger (cmp_bigger), .cmp_equal (cmp_equal), .cmp_smaller (cmp_smaller),
    .t_req (t_req), .t_ack (t_ack), .f_req (f_req), .f_ack (f_ack),
    .out_data (out_data), .err (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 4-phase comparator: fin rises cmp_delay cycles after req, falls lo_delay cycles after req drops.
  always @(posedge clk) begin
    if (fin_reg) begin
      if (!cmp_req || rel) begin
        if (lo_cnt >= lo_delay) begin
          fin_reg <= 1'b0;
          rel     <= 1'b0;
          lo_cnt  <= 0;
        end else begin
          rel    <= 1'b1;
          lo_cnt <= lo_cnt + 1;
        end
      end
    end else if (cmp_req && !cmp_never) begin
      if (hi_cnt + 1 >= cmp_delay) begin
        fin_reg  <= 1'b1;
        hi_cnt   <= 0;
        rise_cyc <= cyc;
      end else begin
        hi_cnt <= hi_cnt + 1;
      end
    end else begin
      hi_cnt <= 0;
    end
  end

  assign cmp_fin     = (cmp_delay == 0 && !cmp_never) ? cmp_req : fin_reg;
  assign cmp_bigger  = (flag_mode == 0) ? (cmp_x > cmp_y)  : (flag_mode == 2);
  assign cmp_equal   = (flag_mode == 0) ? (cmp_x == cmp_y) : (flag_mode == 2);
  assign cmp_smaller = (flag_mode == 0) ? (cmp_x < cmp_y)  : 1'b0;

  always @(negedge clk) if (t_req && f_req) both_cnt <= both_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Branch decision from the condition-code table; fm != 0 means broken one-hot flags.
  function automatic bit ref_taken(input logic [2:0] c, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input int fm);
    if (c == 3'd6) return 1'b1;
    if (c == 3'd7) return 1'b0;
    if (fm != 0) return 1'b0;
    case (c)
      3'd0:    return x == y;
      3'd1:    return x != y;
      3'd2:    return x < y;
      3'd3:    return x <= y;
      3'd4:    return x > y;
      3'd5:    return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] c,
                        input logic [W-1:0] d, input int ack_dly,
                        output bit got_t, output bit got_f, output logic [W-1:0] got_data,
                        output logic [W-1:0] got_cx, output logic [W-1:0] got_cy,
                        output int lat, output bit done);
    done = 1'b0; got_t = 1'b0; got_f = 1'b0; lat = 0;
    got_data = '0; got_cx = '0; got_cy = '0;
    @(negedge clk);
    in_x = x; in_y = y; in_cond = c; in_data = d; in_req = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (t_req || f_req) break;
    end
    if (!(t_req || f_req)) begin
      in_req = 1'b0;
      return;
    end
    got_t = t_req; got_f = f_req; got_data = out_data; got_cx = cmp_x; got_cy = cmp_y;
    repeat (ack_dly) @(negedge clk);
    if (got_t) t_ack = 1'b1; else f_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ack) break;
    end
    in_req = 1'b0;
    if (!in_ack) begin
      t_ack = 1'b0; f_ack = 1'b0;
      return;
    end
    t_ack = 1'b0; f_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!in_ack) break;
    end
    done = !in_ack && !t_req && !f_req;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_req = 1'b0; t_ack = 1'b0; f_ack = 1'b0;
    in_x = '0; in_y = '0; in_cond = 3'd0; in_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ack, cmp_req, t_req, f_req, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ack/req/t/f/err=%b, expected 00000", {in_ack, cmp_req, t_req, f_req, err});
    end
    checks++;
    if ((cmp_x | cmp_y | out_data) !== '0) begin
      errors++;
      $display("FAIL reset_data: got x=%h y=%h data=%h, expected all 0", cmp_x, cmp_y, out_data);
    end
    rst = 1'b0;
    $display("reset done");
  endtask

  task automatic test_gt_delay3();
    bit gt, gf, dn; logic [W-1:0] gd, cx, cy; int lat; logic [W-1:0] d;
    d = $urandom; cmp_delay = 3; lo_delay = 1;
    do_txn(W'(5), W'(3), 3'd4, d, 1, gt, gf, gd, cx, cy, lat, dn);
    $display("gt: x=5 y=3 t=%0b f=%0b data=%h lat=%0d", gt, gf, gd, lat);
    checks++;
    if (!(gt === 1'b1 && gf === 1'b0 && dn)) begin
      errors++;
      $display("FAIL gt_branch: got t=%0b f=%0b done=%0b, expected t=1 f=0 done=1", gt, gf, dn);
    end
    checks++;
    if (gd !== d || cx !== W'(5) || cy !== W'(3)) begin
      errors++;
      $display("FAIL gt_data: got data=%h x=%h y=%h, expected data=%h x=5 y=3", gd, cx, cy, d);
    end
  endtask

  task automatic test_eq_ne_le();
    bit gt, gf, dn; logic [W-1:0] gd, cx, cy; int lat;
    cmp_delay = 2;
    do_txn(W'(7), W'(7), 3'd1, W'(32'h11), 0, gt, gf, gd, cx, cy, lat, dn);
    $display("ne: x=7 y=7 t=%0b f=%0b", gt, gf);
    checks++;
    if (!(gf === 1'b1 && gt === 1'b0 && dn)) begin
      errors++;
      $display("FAIL ne_equal: got t=%0b f=%0b done=%0b, expected t=0 f=1", gt, gf, dn);
    end
    do_txn(W'(7), W'(7), 3'd3, W'(32'h22), 2, gt, gf, gd, cx, cy, lat, dn);
    $display("le: x=7 y=7 t=%0b f=%0b", gt, gf);
    checks++;
    if (!(gt === 1'b1 && gf === 1'b0 && dn && gd === W'(32'h22))) begin
      errors++;
      $display("FAIL le_equal: got t=%0b f=%0b data=%h, expected t=1 f=0 data=22", gt, gf, gd);
    end
  endtask

  task automatic test_zero_latency();
    bit gt, gf, dn; logic [W-1:0] gd, cx, cy; int lat;
    cmp_delay = 0; lo_delay = 0;
    do_txn(W'($urandom), W'($urandom), 3'd6, W'(32'hABCD), 0, gt, gf, gd, cx, cy, lat, dn);
    $display("always zero-delay: t=%0b latency=%0d", gt, lat);
    checks++;
    if (lat != 7 || gt !== 1'b1) begin
      errors++;
      $display("FAIL min_latency: got latency=%0d t=%0b, expected latency=7 t=1", lat, gt);
    end
  endtask

  task automatic test_back_to_back();
    bit gt, gf, dn; logic [W-1:0] gd, cx, cy; int lat; int s2;
    cmp_delay = 1; lo_delay = 8;
    do_txn(W'(9), W'(4), 3'd4, W'(32'h1), 0, gt, gf, gd, cx, cy, lat, dn);
    do_txn(W'(2), W'(4), 3'd5, W'(32'h2), 0, gt, gf, gd, cx, cy, lat, dn);
    s2 = start_cyc;
    $display("back-to-back: second t=%0b f=%0b fin_rise=%0d start=%0d lat=%0d", gt, gf, rise_cyc, s2, lat);
    checks++;
    if (!(gf === 1'b1 && gt === 1'b0 && dn)) begin
      errors++;
      $display("FAIL b2b_branch: got t=%0b f=%0b done=%0b, expected t=0 f=1", gt, gf, dn);
    end
    checks++;
    if (!(rise_cyc > s2)) begin
      errors++;
      $display("FAIL b2b_stale_fin: got dispatch with last fin rise at %0d, required after start %0d", rise_cyc, s2);
    end
    lo_delay = 0;
  endtask

  task automatic test_random();
    bit gt, gf, dn, exp; logic [W-1:0] gd, cx, cy, x, y, d; int lat; logic [2:0] c;
    for (int n = 0; n < 24; n++) begin
      if (n % 4 == 3) begin
        x = $urandom; y = $urandom;
      end else begin
        x = W'($urandom_range(0, 15));
        y = ($urandom_range(0, 3) == 0) ? x : W'($urandom_range(0, 15));
      end
      c = 3'($urandom_range(0, 7));
      d = $urandom;
      cmp_delay = $urandom_range(0, 3);
      lo_delay  = $urandom_range(0, 3);
      exp = ref_taken(c, x, y, 0);
      do_txn(x, y, c, d, $urandom_range(0, 2), gt, gf, gd, cx, cy, lat, dn);
      $display("rand %0d: x=%h y=%h cond=%0d t=%0b f=%0b exp_t=%0b lat=%0d", n, x, y, c, gt, gf, exp, lat);
      checks++;
      if (!(dn && gt === exp && gf === !exp)) begin
        errors++;
        $display("FAIL rand_branch %0d: got t=%0b f=%0b done=%0b, expected t=%0b", n, gt, gf, dn, exp);
      end
      checks++;
      if (gd !== d || cx !== x || cy !== y) begin
        errors++;
        $display("FAIL rand_data %0d: got data=%h x=%h y=%h, expected %h %h %h", n, gd, cx, cy, d, x, y);
      end
    end
  endtask

  task automatic test_bad_flags();
    bit gt, gf, dn, exp; logic [W-1:0] gd, cx, cy; int lat;
    cmp_delay = 2;
    for (int m = 1; m <= 2; m++) begin
      flag_mode = m;
      exp = ref_taken((m == 1) ? 3'd1 : 3'd5, W'(8), W'(3), m);
      do_txn(W'(8), W'(3), (m == 1) ? 3'd1 : 3'd5, W'(32'h55), 0, gt, gf, gd, cx, cy, lat, dn);
      $display("bad flags mode %0d: t=%0b f=%0b err=%0b", m, gt, gf, err);
      checks++;
      if (!(dn && gt === exp && gf === !exp && err === 1'b0)) begin
        errors++;
        $display("FAIL bad_flags %0d: got t=%0b f=%0b err=%0b, expected t=%0b f=%0b err=0", m, gt, gf, err, exp, !exp);
      end
    end
    flag_mode = 0;
  endtask

  task automatic test_timeout();
    int cr, ec; bit saw;
    bit gt, gf, dn; logic [W-1:0] gd, cx, cy; int lat;
    cmp_never = 1'b1; cr = -1; ec = -1; saw = 1'b0;
    @(negedge clk);
    in_x = W'(1); in_y = W'(1); in_cond = 3'd0; in_data = W'(32'h77); in_req = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (cmp_req && cr < 0) cr = i;
      if (t_req || f_req) saw = 1'b1;
      if (err) begin
        ec = i;
        break;
      end
    end
    $display("timeout: cmp_req at %0d err at %0d ack=%0b", cr, ec, in_ack);
    checks++;
    if (cr < 0 || ec < 0 || ec - cr != TO) begin
      errors++;
      $display("FAIL timeout_cycle: got err %0d cycles after cmp_req (cr=%0d ec=%0d), expected %0d", ec - cr, cr, ec, TO);
    end
    checks++;
    if (!(in_ack === 1'b1 && cmp_req === 1'b0 && !saw)) begin
      errors++;
      $display("FAIL timeout_abort: got ack=%0b cmp_req=%0b dispatched=%0b, expected 1 0 0", in_ack, cmp_req, saw);
    end
    in_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!in_ack) break;
    end
    checks++;
    if (in_ack !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rtz: got in_ack=%0b, expected 0", in_ack);
    end
    cmp_never = 1'b0; cmp_delay = 1;
    do_txn(W'(3), W'(9), 3'd2, W'(32'h99), 0, gt, gf, gd, cx, cy, lat, dn);
    $display("after timeout: t=%0b f=%0b err=%0b", gt, gf, err);
    checks++;
    if (!(dn && gt === 1'b1 && err === 1'b1)) begin
      errors++;
      $display("FAIL err_sticky: got t=%0b done=%0b err=%0b, expected t=1 done=1 err=1", gt, dn, err);
    end
  endtask

  task automatic test_reset_mid();
    bit gt, gf, dn; logic [W-1:0] gd, cx, cy; int lat;
    // Reset while waiting for fin high
    cmp_never = 1'b1;
    @(negedge clk);
    in_x = W'(4); in_y = W'(6); in_cond = 3'd2; in_data = W'(32'h44); in_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmp_req) break;
    end
    repeat (4) @(negedge clk);
    rst = 1'b1; in_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ack, cmp_req, t_req, f_req, err} !== 5'b0 || (cmp_x | cmp_y | out_data) !== '0) begin
      errors++;
      $display("FAIL rst_wait_hi: got ack/req/t/f/err=%b x=%h y=%h data=%h, expected all 0",
               {in_ack, cmp_req, t_req, f_req, err}, cmp_x, cmp_y, out_data);
    end
    rst = 1'b0; cmp_never = 1'b0; cmp_delay = 2;
    // Reset while holding a dispatch unacknowledged
    @(negedge clk);
    in_x = W'(1); in_y = W'(2); in_cond = 3'd5; in_data = W'(32'h88); in_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (t_req || f_req) break;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1; in_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ack, cmp_req, t_req, f_req, err} !== 5'b0 || (cmp_x | cmp_y | out_data) !== '0) begin
      errors++;
      $display("FAIL rst_disp: got ack/req/t/f/err=%b x=%h y=%h data=%h, expected all 0",
               {in_ack, cmp_req, t_req, f_req, err}, cmp_x, cmp_y, out_data);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    do_txn(W'(1), W'(2), 3'd2, W'(32'h12), 1, gt, gf, gd, cx, cy, lat, dn);
    $display("after reset: x=1 y=2 LT t=%0b f=%0b", gt, gf);
    checks++;
    if (!(dn && gt === 1'b1 && gf === 1'b0 && gd === W'(32'h12))) begin
      errors++;
      $display("FAIL rst_recover: got t=%0b f=%0b data=%h, expected t=1 f=0 data=12", gt, gf, gd);
    end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL req_overlap: got %0d cycles with t_req and f_req high, expected 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_gt_delay3();
    test_eq_ne_le();
    test_zero_latency();
    test_back_to_back();
    test_random();
    test_bad_flags();
    test_timeout();
    test_reset_mid();
    test_no_overlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
